axi4_rd_pkt_store_fwd: RTL and testbench

- Read-channel counterpart of the team's AXI4 write packet buffering: store-and-forward buffer for AXI4 read data, returning from slave to master.
- Admits an AR only when buffer space for the whole burst is reserved. The downstream R channel therefore never back-pressures.
- Presents R beats upstream only once a complete burst (RLAST stored) is held.
- Sits between an interconnect master port and a slow or bursty slave.

---
 rtl/axi4_rd_pkt_store_fwd.sv | 119 +++++++++++
 tb/tb_axi4_rd_pkt_store_fwd.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rd_pkt_store_fwd.sv
// Store-and-forward buffer for AXI4 read bursts: an AR is admitted only once space for the
// whole burst is reserved; R beats go upstream only per complete burst. Option: AXI4_RD_PKT_LEVEL_EN.
module axi4_rd_pkt_store_fwd #(
  parameter int IDSIZE     = 4,
  parameter int ASIZE      = 32,
  parameter int DSIZE      = 32,
  parameter int LSIZE      = 8,
  parameter int DEPTH      = 4,
  parameter int DATA_DEPTH = 256
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [IDSIZE-1:0] s_arid,
  input  logic [ASIZE-1:0]  s_araddr,
  input  logic [LSIZE-1:0]  s_arlen,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [IDSIZE-1:0] s_rid,
  output logic [DSIZE-1:0]  s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [IDSIZE-1:0] m_arid,
  output logic [ASIZE-1:0]  m_araddr,
  output logic [LSIZE-1:0]  m_arlen,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [IDSIZE-1:0] m_rid,
  input  logic [DSIZE-1:0]  m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              ovf_err
`ifdef AXI4_RD_PKT_LEVEL_EN
  ,
  output logic [$clog2(DATA_DEPTH):0] word_level,
  output logic [$clog2(DEPTH):0]      pkt_level
`endif
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int FW = AW + 1;
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int CW = (FW > LSIZE + 1) ? FW : LSIZE + 1;
  localparam int EW = IDSIZE + DSIZE + 3;

  logic [FW-1:0] free_words;
  logic [OW-1:0] out_cnt;
  logic [OW-1:0] pkt_cnt;
  logic [FW-1:0] wr_ptr;
  logic [FW-1:0] rd_ptr;
  logic [EW-1:0] mem [DATA_DEPTH];
  logic [CW-1:0] burst_words;
  logic          adm;
  logic          ar_hs;
  logic          st_full;
  logic          st_empty;
  logic          wr_en;
  logic          pop;
  logic          pop_last;
  logic          head_last;

  assign m_arid   = s_arid;
  assign m_araddr = s_araddr;
  assign m_arlen  = s_arlen;

  // Compare in a width that holds arlen+1 even if the store is smaller than a max burst.
  // m_rready doubles as the out-of-reset flag: it is low in reset and the first cycle after.
  assign burst_words = CW'(s_arlen) + CW'(1);
  assign adm         = (CW'(free_words) >= burst_words) && (out_cnt < OW'(DEPTH)) && m_rready;
  assign m_arvalid   = s_arvalid && adm;
  assign s_arready   = m_arready && adm;
  assign ar_hs       = s_arvalid && s_arready;

  assign st_empty = (wr_ptr == rd_ptr);
  assign st_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign {s_rid, s_rdata, s_rresp, head_last} = mem[rd_ptr[AW-1:0]];
  assign s_rvalid = (pkt_cnt != '0) && !st_empty;
  assign s_rlast  = s_rvalid && head_last;
  assign pop      = s_rvalid && s_rready;
  assign pop_last = pop && head_last;
  assign wr_en    = m_rvalid && m_rready && (!st_full || pop);

  always_ff @(posedge axi_aclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {m_rid, m_rdata, m_rresp, m_rlast};
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      m_rready   <= 1'b0;
      ovf_err    <= 1'b0;
      free_words <= FW'(DATA_DEPTH);
      out_cnt    <= '0;
      pkt_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      m_rready   <= 1'b1;
      free_words <= free_words - (ar_hs ? FW'(burst_words) : FW'(0)) + (pop ? FW'(1) : FW'(0));
      if (ar_hs && !pop_last)      out_cnt <= out_cnt + OW'(1);
      else if (!ar_hs && pop_last) out_cnt <= out_cnt - OW'(1);
      if (wr_en && m_rlast && !pop_last)      pkt_cnt <= pkt_cnt + OW'(1);
      else if (!(wr_en && m_rlast) && pop_last) pkt_cnt <= pkt_cnt - OW'(1);
      if (wr_en) wr_ptr <= wr_ptr + FW'(1);
      if (pop)   rd_ptr <= rd_ptr + FW'(1);
      if (m_rvalid && m_rready && !wr_en) ovf_err <= 1'b1;
    end
  end

`ifdef AXI4_RD_PKT_LEVEL_EN
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) word_level <= '0;
    else              word_level <= word_level + (wr_en ? FW'(1) : FW'(0)) - (pop ? FW'(1) : FW'(0));
  end
  assign pkt_level = pkt_cnt;
`endif
endmodule

// File: tb/tb_axi4_rd_pkt_store_fwd.sv
// Bench for axi4_rd_pkt_store_fwd: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the buffer updated once per cycle.
module tb_axi4_rd_pkt_store_fwd;
  localparam int DD = 16;
  localparam int DP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  s_arid = '0;
  logic [31:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [3:0]  m_rid = '0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rlast = 1'b0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;
  logic        ovf_err;
`ifdef AXI4_RD_PKT_LEVEL_EN
  logic [4:0]  word_level;
  logic [2:0]  pkt_level;
`endif

  axi4_rd_pkt_store_fwd #(.IDSIZE(4), .ASIZE(32), .DSIZE(32), .LSIZE(8), .DEPTH(DP), .DATA_DEPTH(DD)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .ovf_err(ovf_err)
`ifdef AXI4_RD_PKT_LEVEL_EN
    , .word_level(word_level), .pkt_level(pkt_level)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } beat_t;
  typedef struct { logic [3:0] id; int len; } burst_t;

  beat_t  mq[$];
  burst_t sq[$];
  int     m_free = DD;
  int     m_out = 0;
  bit     m_run = 1'b0;
  bit     m_ovf = 1'b0;
  int     n_vec = 0;
  int     n_err = 0;
  bit     fire_ar = 1'b0;
  int     bidx = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: store is a queue of beats; a burst is releasable once its last beat is queued.
  always @(negedge clk) begin
    int    nlast;
    bit    e_rv, e_adm, e_arr, pop, arhs;
    beat_t b;
    if (!rst_n) begin
      mq.delete();
      m_free = DD; m_out = 0; m_run = 1'b0; m_ovf = 1'b0; fire_ar = 1'b0;
      chk("rst_s_arready", s_arready, 0);
      chk("rst_m_arvalid", m_arvalid, 0);
      chk("rst_s_rvalid", s_rvalid, 0);
      chk("rst_s_rlast", s_rlast, 0);
      chk("rst_m_rready", m_rready, 0);
      chk("rst_ovf_err", ovf_err, 0);
    end else begin
      nlast = 0;
      foreach (mq[i]) if (mq[i].last) nlast++;
      e_rv  = (nlast > 0);
      e_adm = m_run && (m_free >= int'(s_arlen) + 1) && (m_out < DP);
      e_arr = m_arready && e_adm;
      chk("m_arvalid", m_arvalid, s_arvalid && e_adm);
      chk("s_arready", s_arready, e_arr);
      chk("m_arid", m_arid, s_arid);
      chk("m_araddr", m_araddr, s_araddr);
      chk("m_arlen", m_arlen, s_arlen);
      chk("m_rready", m_rready, m_run);
      chk("s_rvalid", s_rvalid, e_rv);
      chk("ovf_err", ovf_err, m_ovf);
      if (e_rv) begin
        chk("s_rid", s_rid, mq[0].id);
        chk("s_rdata", s_rdata, mq[0].data);
        chk("s_rresp", s_rresp, mq[0].resp);
        chk("s_rlast", s_rlast, mq[0].last);
      end else begin
        chk("s_rlast_idle", s_rlast, 0);
      end
      fire_ar = s_arvalid && s_arready;
      arhs = s_arvalid && e_arr;
      pop  = e_rv && s_rready;
      if (pop) begin
        b = mq.pop_front();
        m_free++;
        if (b.last) m_out--;
      end
      if (arhs) begin
        m_free -= int'(s_arlen) + 1;
        m_out++;
      end
      if (m_run && m_rvalid) begin
        if (mq.size() < DD) begin
          b.id = m_rid; b.data = m_rdata; b.resp = m_rresp; b.last = m_rlast;
          mq.push_back(b);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_run = 1'b1;
    end
  end

  task automatic rnd_step(input bit gen);
    burst_t nb;
    if (s_arvalid && fire_ar) begin
      nb.id = s_arid; nb.len = int'(s_arlen);
      sq.push_back(nb);
      s_arvalid = 1'b0;
    end
    if (!s_arvalid && gen && $urandom_range(0, 3) == 0) begin
      s_arvalid = 1'b1;
      s_arid    = 4'($urandom_range(0, 15));
      s_araddr  = $urandom;
      s_arlen   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(8, 15)) : 8'($urandom_range(0, 3));
    end
    m_arready = gen ? ($urandom_range(0, 9) < 7) : 1'b1;
    if (m_rvalid) begin
      if (m_rlast) begin
        nb = sq.pop_front();
        bidx = 0;
      end else begin
        bidx++;
      end
    end
    if (sq.size() > 0 && (!gen || $urandom_range(0, 9) < 6)) begin
      m_rvalid = 1'b1;
      m_rid    = sq[0].id;
      m_rdata  = $urandom;
      m_rresp  = 2'($urandom_range(0, 3));
      m_rlast  = (bidx == sq[0].len);
    end else begin
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
    end
    s_rready = gen ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  initial begin
    repeat (3) cyc();
    s_arvalid = 1'b1; s_arlen = 8'd0; m_arready = 1'b1; #1;
    chk("reset_m_arvalid", m_arvalid, 0);
    chk("reset_s_arready", s_arready, 0);
    chk("reset_m_rready", m_rready, 0);
    s_arvalid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();

    // Single 4-beat burst
    s_arvalid = 1'b1; s_arid = 4'd5; s_araddr = 32'h1000; s_arlen = 8'd3; #1;
    chk("t1_m_arvalid", m_arvalid, 1);
    chk("t1_s_arready", s_arready, 1);
    chk("t1_m_araddr", m_araddr, 32'h1000);
    cyc();
    s_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1; m_rid = 4'd5; m_rdata = 32'hA0 + i; m_rresp = 2'd0; m_rlast = (i == 3); #1;
      chk("t1_no_early_rvalid", s_rvalid, 0);
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t1_rvalid", s_rvalid, 1);
      chk("t1_rdata", s_rdata, 32'hA0 + i);
      chk("t1_rlast", s_rlast, (i == 3));
      chk("t1_rid", s_rid, 4'd5);
      cyc();
    end
    s_rready = 1'b0; #1;
    chk("t1_drained", s_rvalid, 0);
    cyc();

    // Credit stall: arlen=15 consumes the whole store
    s_arvalid = 1'b1; s_arid = 4'd1; s_araddr = 32'h2000; s_arlen = 8'd15; #1;
    chk("t2_ar1_accept", s_arready, 1);
    cyc();
    s_arid = 4'd2; s_araddr = 32'h3000; s_arlen = 8'd0; #1;
    chk("t2_ar2_held", s_arready, 0);
    chk("t2_ar2_mvalid", m_arvalid, 0);
    for (int i = 0; i < 16; i++) begin
      m_rvalid = 1'b1; m_rid = 4'd1; m_rdata = 32'h200 + i; m_rlast = (i == 15); #1;
      chk("t2_hold", s_arready, 0);
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 1'b1; #1;
    chk("t2_head", s_rdata, 32'h200);
    chk("t2_still_held", s_arready, 0);
    cyc();
    #1;
    chk("t2_ar2_admit", s_arready, 1);
    chk("t2_ar2_mvalid1", m_arvalid, 1);
    cyc();
    s_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rid = 4'd2; m_rdata = 32'h300; m_rlast = 1'b1;
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    repeat (20) cyc();

    // Outstanding limit
    for (int k = 0; k < 4; k++) begin
      s_arvalid = 1'b1; s_arid = 4'(k); s_araddr = 32'h4000 + 32'(k); s_arlen = 8'd0; #1;
      chk("t3_accept", s_arready, 1);
      cyc();
    end
    s_arid = 4'd4; #1;
    chk("t3_fifth_blocked", s_arready, 0);
    m_rvalid = 1'b1; m_rid = 4'd0; m_rdata = 32'h400; m_rlast = 1'b1;
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0; #1;
    chk("t3_blocked_until_pop", s_arready, 0);
    cyc();
    #1;
    chk("t3_fifth_admit", s_arready, 1);
    cyc();
    s_arvalid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      m_rvalid = 1'b1; m_rid = 4'(k); m_rdata = 32'h400 + 32'(k); m_rlast = 1'b1;
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    repeat (6) cyc();

    // Partial burst held back; head stable under back-pressure
    s_rready = 1'b0;
    s_arvalid = 1'b1; s_arid = 4'd7; s_araddr = 32'h5000; s_arlen = 8'd3; #1;
    chk("t4_accept", s_arready, 1);
    cyc();
    s_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_rvalid = 1'b1; m_rid = 4'd7; m_rdata = 32'hB0 + i; m_rlast = 1'b0;
      cyc();
    end
    m_rvalid = 1'b0; #1;
    chk("t4_partial", s_rvalid, 0);
    cyc();
    m_rvalid = 1'b1; m_rdata = 32'hB3; m_rlast = 1'b1;
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_rvalid", s_rvalid, 1);
      chk("t4_stable", s_rdata, 32'hB0);
      cyc();
    end
    s_rready = 1'b1;
    repeat (6) cyc();

    // Overflow beyond reservation
    s_rready = 1'b0;
    s_arvalid = 1'b1; s_arid = 4'd3; s_araddr = 32'h6000; s_arlen = 8'd15; #1;
    chk("t5_accept", s_arready, 1);
    cyc();
    s_arvalid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      m_rvalid = 1'b1; m_rid = 4'd3; m_rdata = (i == 16) ? 32'hDEAD : 32'h600 + i; m_rlast = (i == 15); #1;
      chk("t5_no_ovf_yet", ovf_err, 0);
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; #1;
    chk("t5_ovf_set", ovf_err, 1);
    chk("t5_m_rready", m_rready, 1);
    s_rready = 1'b1;
    repeat (18) cyc();
    #1;
    chk("t5_ovf_sticky", ovf_err, 1);
    cyc();

    // Reset in the middle of an upstream transfer
    s_rready = 1'b0;
    s_arvalid = 1'b1; s_arid = 4'd9; s_araddr = 32'h7000; s_arlen = 8'd7;
    cyc();
    s_arvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_rvalid = 1'b1; m_rid = 4'd9; m_rdata = 32'h700 + i; m_rlast = (i == 7);
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 1'b1;
    cyc(); cyc();
    rst_n = 1'b0; #1;
    chk("t6_rvalid_async", s_rvalid, 0);
    chk("t6_ovf_cleared", ovf_err, 0);
    chk("t6_m_rready", m_rready, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    s_arvalid = 1'b1; s_arid = 4'd0; s_araddr = 32'h8000; s_arlen = 8'd15; m_arready = 1'b0; #1;
    chk("t6_full_credit", m_arvalid, 1);
    s_arvalid = 1'b0;
    cyc();

    // Randomized traffic, then drain
    for (int c = 0; c < 3000; c++) begin
      rnd_step(1'b1);
      cyc();
    end
    for (int c = 0; c < 2000 && (s_arvalid || m_rvalid || sq.size() > 0 || mq.size() > 0); c++) begin
      rnd_step(1'b0);
      cyc();
    end
    chk("drain_done", 64'(sq.size() + mq.size()) + 64'(s_arvalid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
